// File: rtl/commit_trace_buffer.sv
// Multi-channel architectural event tracer: per-channel holding registers feed a
// fixed-priority arbiter into a timestamped first-word-fall-through FIFO.
module commit_trace_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NCH   = 2,
    parameter int unsigned TS_W  = 32,
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NCH-1:0]      ch_valid,
    input  logic [NCH*XLEN-1:0] ch_addr,
    input  logic [NCH*XLEN-1:0] ch_data,
    output logic                trc_valid,
    input  logic                trc_ready,
    output logic [CW-1:0]       trc_ch,
    output logic [XLEN-1:0]     trc_addr,
    output logic [XLEN-1:0]     trc_data,
    output logic [TS_W-1:0]     trc_ts,
    output logic [LW-1:0]       level,
    output logic                full,
    output logic                empty,
    output logic [15:0]         ovf_cnt
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned OVF_W = 16;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [NCH-1:0]   occ_q, occ_d;
    logic [XLEN-1:0]  haddr_q [NCH];
    logic [XLEN-1:0]  haddr_d [NCH];
    logic [XLEN-1:0]  hdata_q [NCH];
    logic [XLEN-1:0]  hdata_d [NCH];
    logic [TS_W-1:0]  hts_q   [NCH];
    logic [TS_W-1:0]  hts_d   [NCH];

    logic [CW-1:0]    mem_ch_q   [DEPTH];
    logic [XLEN-1:0]  mem_addr_q [DEPTH];
    logic [XLEN-1:0]  mem_data_q [DEPTH];
    logic [TS_W-1:0]  mem_ts_q   [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    logic             vld_q, vld_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;
    logic [XLEN-1:0]  out_addr_q, out_addr_d;
    logic [XLEN-1:0]  out_data_q, out_data_d;
    logic [TS_W-1:0]  out_ts_q, out_ts_d;

    logic             push_req_c, push_c, pop_c;
    logic [CW-1:0]    push_ch_c;
    logic [XLEN-1:0]  push_addr_c, push_data_c;
    logic [TS_W-1:0]  push_ts_c;
    logic [31:0]      drops_c, ovf_sum_c;

    // Fixed priority: the lowest-index occupied holding register wins the push slot.
    always_comb begin
        push_req_c  = 1'b0;
        push_ch_c   = '0;
        push_addr_c = '0;
        push_data_c = '0;
        push_ts_c   = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (occ_q[i]) begin
                push_req_c  = 1'b1;
                push_ch_c   = CW'(i);
                push_addr_c = haddr_q[i];
                push_data_c = hdata_q[i];
                push_ts_c   = hts_q[i];
            end
        end
        pop_c  = vld_q & trc_ready;
        push_c = push_req_c & (~full_q | pop_c);
    end

    // Capture into holding registers; a slot freed by this cycle's push may reload.
    always_comb begin
        ts_d    = en ? ts_q + TS_W'(1) : ts_q;
        occ_d   = occ_q;
        drops_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            haddr_d[i] = haddr_q[i];
            hdata_d[i] = hdata_q[i];
            hts_d[i]   = hts_q[i];
            if (push_c && (push_ch_c == CW'(i))) begin
                occ_d[i] = 1'b0;
            end
            if (en && ch_valid[i]) begin
                if (!occ_q[i] || (push_c && (push_ch_c == CW'(i)))) begin
                    occ_d[i]   = 1'b1;
                    haddr_d[i] = ch_addr[i*XLEN +: XLEN];
                    hdata_d[i] = ch_data[i*XLEN +: XLEN];
                    hts_d[i]   = ts_q;
                end else begin
                    drops_c = drops_c + 32'd1;
                end
            end
        end
        ovf_sum_c = 32'(ovf_q) + drops_c;
        ovf_d     = (ovf_sum_c > 32'h0000_FFFF) ? 16'hFFFF : OVF_W'(ovf_sum_c);
    end

    // FIFO bookkeeping and next head; the head is registered so trc_* are flop outputs.
    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_c && !pop_c) begin
            cnt_d = cnt_q + LW'(1);
        end else if (!push_c && pop_c) begin
            cnt_d = cnt_q - LW'(1);
        end
        full_d     = (cnt_d == LW'(DEPTH));
        empty_d    = (cnt_d == '0);
        vld_d      = ~empty_d;
        out_ch_d   = out_ch_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_ts_d   = out_ts_q;
        if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            out_ch_d   = push_ch_c;
            out_addr_d = push_addr_c;
            out_data_d = push_data_c;
            out_ts_d   = push_ts_c;
        end else if (!empty_d) begin
            out_ch_d   = mem_ch_q[rd_ptr_d];
            out_addr_d = mem_addr_q[rd_ptr_d];
            out_data_d = mem_data_q[rd_ptr_d];
            out_ts_d   = mem_ts_q[rd_ptr_d];
        end
    end

    // Storage array carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_ch_q[wr_ptr_q]   <= push_ch_c;
            mem_addr_q[wr_ptr_q] <= push_addr_c;
            mem_data_q[wr_ptr_q] <= push_data_c;
            mem_ts_q[wr_ptr_q]   <= push_ts_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            occ_q      <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                haddr_q[i] <= '0;
                hdata_q[i] <= '0;
                hts_q[i]   <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= '0;
            vld_q      <= 1'b0;
            out_ch_q   <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_ts_q   <= '0;
        end else begin
            ts_q       <= ts_d;
            occ_q      <= occ_d;
            for (int i = 0; i < int'(NCH); i++) begin
                haddr_q[i] <= haddr_d[i];
                hdata_q[i] <= hdata_d[i];
                hts_q[i]   <= hts_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            vld_q      <= vld_d;
            out_ch_q   <= out_ch_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_ts_q   <= out_ts_d;
        end
    end

    assign trc_valid = vld_q;
    assign trc_ch    = out_ch_q;
    assign trc_addr  = out_addr_q;
    assign trc_data  = out_data_q;
    assign trc_ts    = out_ts_q;
    assign level     = cnt_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios then random traffic, all
// checked against a queue-based event model.
module tb_commit_trace_buffer;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NCH   = 3;
    localparam int unsigned TS_W  = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned LW    = 3;

    logic                clk = 1'b0;
    logic                rst, en, trc_ready;
    logic [NCH-1:0]      ch_valid;
    logic [NCH*XLEN-1:0] ch_addr, ch_data;
    logic                trc_valid, full, empty;
    logic [CW-1:0]       trc_ch;
    logic [XLEN-1:0]     trc_addr, trc_data;
    logic [TS_W-1:0]     trc_ts;
    logic [LW-1:0]       level;
    logic [15:0]         ovf_cnt;

    always #5 clk = ~clk;

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NCH(NCH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_addr(ch_addr),
        .ch_data(ch_data), .trc_valid(trc_valid), .trc_ready(trc_ready),
        .trc_ch(trc_ch), .trc_addr(trc_addr), .trc_data(trc_data), .trc_ts(trc_ts),
        .level(level), .full(full), .empty(empty), .ovf_cnt(ovf_cnt)
    );

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [31:0] data;
        int          ts;
    } ev_t;

    ev_t mq [$];
    ev_t mhold [NCH];
    bit  mocc [NCH];
    int  m_ts;
    int  m_ovf;
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit  do_pop, do_push;
        int  sel, drops;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < int'(NCH); i++) mocc[i] = 1'b0;
            m_ts  = 0;
            m_ovf = 0;
            return;
        end
        do_pop = (mq.size() > 0) && trc_ready;
        sel = -1;
        for (int i = 0; i < int'(NCH); i++) if (mocc[i] && sel < 0) sel = i;
        do_push = (sel >= 0) && ((mq.size() < int'(DEPTH)) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(mhold[sel]);
            mocc[sel] = 1'b0;
        end
        drops = 0;
        if (en) begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (ch_valid[i]) begin
                    if (mocc[i]) drops++;
                    else begin
                        mhold[i] = '{i, ch_addr[i*XLEN +: XLEN], ch_data[i*XLEN +: XLEN], m_ts};
                        mocc[i]  = 1'b1;
                    end
                end
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
        m_ovf = (m_ovf + drops > 65535) ? 65535 : m_ovf + drops;
    endtask

    task automatic compare_all();
        chk("trc_valid", 64'(trc_valid), 64'(mq.size() != 0));
        chk("level", 64'(level), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == int'(DEPTH)));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk("trc_ch", 64'(trc_ch), 64'(mq[0].ch));
            chk("trc_addr", 64'(trc_addr), 64'(mq[0].addr));
            chk("trc_data", 64'(trc_data), 64'(mq[0].data));
            chk("trc_ts", 64'(trc_ts), 64'(mq[0].ts));
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [NCH-1:0] v, input logic rdy);
        rst       = r;
        en        = e;
        ch_valid  = v;
        trc_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_ch(input int i, input logic [31:0] a, input logic [31:0] d);
        ch_addr[i*XLEN +: XLEN] = a;
        ch_data[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; trc_ready = 1'b0; ch_valid = '0;
        ch_addr = '0; ch_data = '0;

        // Reset state
        step(1'b1, 1'b0, 3'b000, 1'b0);
        chk("rst_ch", 64'(trc_ch), 64'd0);
        chk("rst_addr", 64'(trc_addr), 64'd0);
        chk("rst_data", 64'(trc_data), 64'd0);
        chk("rst_ts", 64'(trc_ts), 64'd0);

        // Single event captured at ts=3, visible two cycles later
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 3'b000, 1'b0);
        set_ch(0, 32'd5, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        chk("single_lat1_valid", 64'(trc_valid), 64'd0);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk("single_valid", 64'(trc_valid), 64'd1);
        chk("single_ch", 64'(trc_ch), 64'd0);
        chk("single_addr", 64'(trc_addr), 64'd5);
        chk("single_data", 64'(trc_data), 64'hDEAD_BEEF);
        chk("single_ts", 64'(trc_ts), 64'd3);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("single_empty", 64'(empty), 64'd1);

        // Collision on ch0 and ch1 at ts=10
        for (int k = 0; k < 20 && m_ts != 10; k++) step(1'b0, 1'b1, 3'b000, 1'b0);
        set_ch(0, 32'h100, 32'hA0A0_0000);
        set_ch(1, 32'h200, 32'hB1B1_1111);
        step(1'b0, 1'b1, 3'b011, 1'b1);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("coll_first_ch", 64'(trc_ch), 64'd0);
        chk("coll_first_ts", 64'(trc_ts), 64'd10);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("coll_second_ch", 64'(trc_ch), 64'd1);
        chk("coll_second_ts", 64'(trc_ts), 64'd10);
        chk("coll_ovf", 64'(ovf_cnt), 64'd0);
        step(1'b0, 1'b1, 3'b000, 1'b1);

        // Backpressure: 7 back-to-back ch0 events into a 4-deep FIFO
        for (int k = 0; k < 7; k++) begin
            set_ch(0, 32'(k), 32'(100 + k));
            step(1'b0, 1'b1, 3'b001, 1'b0);
        end
        chk("bp_level", 64'(level), 64'd4);
        chk("bp_full", 64'(full), 64'd1);
        chk("bp_ovf", 64'(ovf_cnt), 64'd2);
        chk("bp_head", 64'(trc_data), 64'd100);
        // Full with concurrent pop and push of the held event
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("fullpp_level", 64'(level), 64'd4);
        chk("fullpp_head", 64'(trc_data), 64'd101);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 3'b000, 1'b1);
            chk("bp_drain_order", 64'(trc_data), 64'(102 + k));
        end
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("bp_drained", 64'(empty), 64'd1);

        // Timestamp wrap: events at 15 and 0
        step(1'b1, 1'b0, 3'b000, 1'b0);
        for (int k = 0; k < 20 && m_ts != 15; k++) step(1'b0, 1'b1, 3'b000, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk("wrap_level", 64'(level), 64'd2);
        chk("wrap_ts15", 64'(trc_ts), 64'd15);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("wrap_ts0", 64'(trc_ts), 64'd0);
        step(1'b0, 1'b1, 3'b000, 1'b1);

        // Reset mid-operation with entries queued, events held and drops counted
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 32'(k), 32'(200 + k));
            set_ch(2, 32'(k), 32'(300 + k));
            step(1'b0, 1'b1, 3'b101, 1'b0);
        end
        chk("pre_rst_level", 64'(level), 64'd3);
        chk("pre_rst_ovf", 64'(ovf_cnt), 64'd3);
        step(1'b1, 1'b1, 3'b101, 1'b1);
        chk("mid_rst_valid", 64'(trc_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
        set_ch(0, 32'h55, 32'h1234_5678);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        step(1'b0, 1'b1, 3'b000, 1'b0);
        chk("post_rst_valid", 64'(trc_valid), 64'd1);
        chk("post_rst_ts", 64'(trc_ts), 64'd0);
        chk("post_rst_data", 64'(trc_data), 64'h1234_5678);

        // Random traffic with alternating light/heavy backpressure
        for (int c = 0; c < 3000; c++) begin
            ch_addr = {$urandom(), $urandom(), $urandom()};
            ch_data = {$urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) != 0,
                 NCH'($urandom() & $urandom()),
                 ((c / 200) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
